// File: rtl/periph_arbiter.sv
// -----------------------------------------------------------------------------
// periph_arbiter
//
// Merges the instruction-fetch port (imem) and the data port (dmem) onto one
// single-slave peripheral channel (valid/instr/addr/wdata/wstrb -> rdata/ready).
// Each port owns a one-deep pending register. An IDLE/WAIT FSM forwards one
// request at a time with round-robin priority. A watchdog completes with an
// error any request that the peripheral never acknowledges.
//
// Parameters
//   TIMEOUT      waiting cycles without per_ready before an error completion (>=1)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears all state and outputs
//   imem_valid   fetch request pulse
//   imem_addr    fetch address
//   imem_rdata   fetch response data (0 unless imem_ready)
//   imem_ready   fetch completion pulse
//   imem_error   qualifies imem_ready: completion was a timeout
//   dmem_valid   data request pulse
//   dmem_addr    data address
//   dmem_wdata   data write value
//   dmem_wstrb   byte strobes, 0 means read
//   dmem_rdata   data response data (0 unless dmem_ready)
//   dmem_ready   data completion pulse
//   dmem_error   qualifies dmem_ready: completion was a timeout
//   per_valid    peripheral request pulse
//   per_instr    forwarded request came from the fetch port
//   per_addr     forwarded address
//   per_wdata    forwarded write data (0 for fetches)
//   per_wstrb    forwarded strobes (0 for fetches)
//   per_rdata    peripheral response data
//   per_ready    peripheral response strobe
// -----------------------------------------------------------------------------
module periph_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_error,

  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,

  output logic        per_valid,
  output logic        per_instr,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wstrb,
  input  logic [31:0] per_rdata,
  input  logic        per_ready
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]      r_state;

  logic            r_iPend;
  logic [31:0]     r_iAddr;

  logic            r_dPend;
  logic [31:0]     r_dAddr;
  logic [31:0]     r_dWdata;
  logic [3:0]      r_dWstrb;

  logic            r_selDmem;
  logic            r_lastDmem;
  logic [WD_W-1:0] r_wdog;

  logic            r_perValid;
  logic            r_perInstr;
  logic [31:0]     r_perAddr;
  logic [31:0]     r_perWdata;
  logic [3:0]      r_perWstrb;

  logic            r_iReady;
  logic            r_iError;
  logic [31:0]     r_iRdata;
  logic            r_dReady;
  logic            r_dError;
  logic [31:0]     r_dRdata;

  logic            w_inWait;
  logic            w_issue;
  logic            w_pickDmem;
  logic            w_ackOk;
  logic            w_timeout;
  logic            w_done;
  logic            w_iDone;
  logic            w_dDone;

  // Arbitration and completion decode. On a tie the port that was not served
  // last wins; after reset "last served" means imem, so dmem takes the first
  // tie. A response arriving in the same cycle as the watchdog limit counts as
  // a normal acknowledge, so the timeout term is masked by per_ready.
  always_comb begin
    w_inWait   = (r_state == ST_WAIT);
    w_issue    = (r_state == ST_IDLE) && (r_iPend || r_dPend);
    w_pickDmem = r_dPend && (!r_iPend || !r_lastDmem);
    w_ackOk    = w_inWait && per_ready;
    w_timeout  = w_inWait && !per_ready && (r_wdog == WD_MAX);
    w_done     = w_ackOk || w_timeout;
    w_iDone    = w_done && !r_selDmem;
    w_dDone    = w_done &&  r_selDmem;
  end

  // Fetch pending register. Completion of the port's own request has priority,
  // and a valid seen while pending is still set is dropped. A valid issued in
  // the cycle imem_ready is high is captured because pending already cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iPend <= 1'b0;
      r_iAddr <= '0;
    end else if (w_iDone) begin
      r_iPend <= 1'b0;
    end else if (imem_valid && !r_iPend) begin
      r_iPend <= 1'b1;
      r_iAddr <= imem_addr;
    end
  end

  // Data pending register, same capture/drop/clear rules as the fetch side.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dPend  <= 1'b0;
      r_dAddr  <= '0;
      r_dWdata <= '0;
      r_dWstrb <= '0;
    end else if (w_dDone) begin
      r_dPend  <= 1'b0;
    end else if (dmem_valid && !r_dPend) begin
      r_dPend  <= 1'b1;
      r_dAddr  <= dmem_addr;
      r_dWdata <= dmem_wdata;
      r_dWstrb <= dmem_wstrb;
    end
  end

  // Two-state sequencer. IDLE forwards a pending request and moves to WAIT;
  // WAIT returns to IDLE on acknowledge or watchdog expiry. per_ready in IDLE
  // has no effect because w_done is qualified by WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_issue) r_state <= ST_WAIT;
        ST_WAIT: if (w_done)  r_state <= ST_IDLE;
        default:              r_state <= ST_IDLE;
      endcase
    end
  end

  // Remember which port owns the outstanding request, and which port was last
  // completed for the round-robin tie break.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_selDmem  <= 1'b0;
      r_lastDmem <= 1'b0;
    end else begin
      if (w_issue) begin
        r_selDmem <= w_pickDmem;
      end
      if (w_done) begin
        r_lastDmem <= r_selDmem;
      end
    end
  end

  // Watchdog: zero in the first WAIT cycle, counting up once per WAIT cycle
  // until the request completes. It never passes WD_MAX because reaching it
  // without per_ready forces completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if (w_issue) begin
      r_wdog <= '0;
    end else if (w_inWait && !w_done) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Forwarded request. per_valid is a one-cycle pulse on the first WAIT cycle;
  // the request fields are only reloaded on issue, so they stay stable for the
  // whole WAIT period. Fetches always forward wdata=0 and wstrb=0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perValid <= 1'b0;
      r_perInstr <= 1'b0;
      r_perAddr  <= '0;
      r_perWdata <= '0;
      r_perWstrb <= '0;
    end else begin
      r_perValid <= w_issue;
      if (w_issue) begin
        r_perInstr <= !w_pickDmem;
        r_perAddr  <= w_pickDmem ? r_dAddr  : r_iAddr;
        r_perWdata <= w_pickDmem ? r_dWdata : 32'h0;
        r_perWstrb <= w_pickDmem ? r_dWstrb : 4'h0;
      end
    end
  end

  // Port responses. Ready and error are single-cycle pulses and rdata is zero
  // except in the ready cycle of a normal acknowledge; a timeout returns 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iReady <= 1'b0;
      r_iError <= 1'b0;
      r_iRdata <= '0;
      r_dReady <= 1'b0;
      r_dError <= 1'b0;
      r_dRdata <= '0;
    end else begin
      r_iReady <= w_iDone;
      r_iError <= w_iDone && w_timeout;
      r_iRdata <= (w_iDone && w_ackOk) ? per_rdata : 32'h0;
      r_dReady <= w_dDone;
      r_dError <= w_dDone && w_timeout;
      r_dRdata <= (w_dDone && w_ackOk) ? per_rdata : 32'h0;
    end
  end

  assign per_valid  = r_perValid;
  assign per_instr  = r_perInstr;
  assign per_addr   = r_perAddr;
  assign per_wdata  = r_perWdata;
  assign per_wstrb  = r_perWstrb;

  assign imem_ready = r_iReady;
  assign imem_error = r_iError;
  assign imem_rdata = r_iRdata;
  assign dmem_ready = r_dReady;
  assign dmem_error = r_dError;
  assign dmem_rdata = r_dRdata;

endmodule

// File: tb/tb_periph_arbiter.sv
// -----------------------------------------------------------------------------
// tb_periph_arbiter
//
// Drives periph_arbiter (TIMEOUT=15) through the directed scenarios of the
// block's behaviour and then through randomized traffic with a randomized
// peripheral responder. A transaction-level reference model predicts every
// output for every cycle; all comparisons go through checkOutput.
// -----------------------------------------------------------------------------
module tb_periph_arbiter;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_error;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_error;
  logic        per_valid;
  logic        per_instr;
  logic [31:0] per_addr;
  logic [31:0] per_wdata;
  logic [3:0]  per_wstrb;
  logic [31:0] per_rdata;
  logic        per_ready;

  periph_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_error (imem_error),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .dmem_error (dmem_error),
    .per_valid  (per_valid),
    .per_instr  (per_instr),
    .per_addr   (per_addr),
    .per_wdata  (per_wdata),
    .per_wstrb  (per_wstrb),
    .per_rdata  (per_rdata),
    .per_ready  (per_ready)
  );

  always #5 clock = ~clock;

  // Stimulus for the cycle about to be applied.
  logic        nIValid;
  logic [31:0] nIAddr;
  logic        nDValid;
  logic [31:0] nDAddr;
  logic [31:0] nDWdata;
  logic [3:0]  nDWstrb;
  logic        nPReady;
  logic [31:0] nPRdata;
  logic        nReset;
  bit          autoPer;

  int cyc;
  int nChecks;
  int nBad;

  // Reference model: index 0 is the fetch port, 1 the data port. A request is
  // "outstanding" from the cycle its per_valid is seen until its completion
  // cycle; its age is simply the current cycle minus the issue cycle.
  bit          mPend [2];
  logic [31:0] mAddr [2];
  logic [31:0] mWdata[2];
  logic [3:0]  mWstrb[2];
  bit          mBusy;
  int          mPort;
  int          mLast;
  int          mIssueCyc;
  int          respMode;
  int          respCyc;

  logic        eVal;
  logic        eInstr;
  logic [31:0] eAddr;
  logic [31:0] eWdata;
  logic [3:0]  eWstrb;
  logic        eIReady;
  logic        eIErr;
  logic [31:0] eIRdata;
  logic        eDReady;
  logic        eDErr;
  logic [31:0] eDRdata;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nBad++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // Compare every DUT output with the model's prediction for this cycle.
  task automatic checkAll();
    checkOutput("per_valid",  32'(per_valid),  32'(eVal));
    checkOutput("per_instr",  32'(per_instr),  32'(eInstr));
    checkOutput("per_addr",   per_addr,        eAddr);
    checkOutput("per_wdata",  per_wdata,       eWdata);
    checkOutput("per_wstrb",  32'(per_wstrb),  32'(eWstrb));
    checkOutput("imem_ready", 32'(imem_ready), 32'(eIReady));
    checkOutput("imem_error", 32'(imem_error), 32'(eIErr));
    checkOutput("imem_rdata", imem_rdata,      eIRdata);
    checkOutput("dmem_ready", 32'(dmem_ready), 32'(eDReady));
    checkOutput("dmem_error", 32'(dmem_error), 32'(eDErr));
    checkOutput("dmem_rdata", dmem_rdata,      eDRdata);
  endtask

  // While reset is asserted every output must already be zero.
  task automatic checkZeros();
    checkOutput("rst_per_valid",  32'(per_valid),  32'h0);
    checkOutput("rst_per_instr",  32'(per_instr),  32'h0);
    checkOutput("rst_per_addr",   per_addr,        32'h0);
    checkOutput("rst_per_wdata",  per_wdata,       32'h0);
    checkOutput("rst_per_wstrb",  32'(per_wstrb),  32'h0);
    checkOutput("rst_imem_ready", 32'(imem_ready), 32'h0);
    checkOutput("rst_imem_error", 32'(imem_error), 32'h0);
    checkOutput("rst_imem_rdata", imem_rdata,      32'h0);
    checkOutput("rst_dmem_ready", 32'(dmem_ready), 32'h0);
    checkOutput("rst_dmem_error", 32'(dmem_error), 32'h0);
    checkOutput("rst_dmem_rdata", dmem_rdata,      32'h0);
  endtask

  // Model state right after reset: nothing pending, nothing outstanding, all
  // outputs zero, and the fetch port counts as last served.
  task automatic modelReset();
    for (int p = 0; p < 2; p++) begin
      mPend[p]  = 1'b0;
      mAddr[p]  = '0;
      mWdata[p] = '0;
      mWstrb[p] = '0;
    end
    mBusy    = 1'b0;
    mPort    = 0;
    mLast    = 0;
    respMode = 0;
    eVal = 0; eInstr = 0; eAddr = '0; eWdata = '0; eWstrb = '0;
    eIReady = 0; eIErr = 0; eIRdata = '0;
    eDReady = 0; eDErr = 0; eDRdata = '0;
  endtask

  // Advance the model by one cycle using this cycle's inputs, producing the
  // expected outputs of the next cycle.
  task automatic modelStep();
    bit oldPend[2];
    bit done;
    bit tmo;
    int p;
    oldPend = mPend;
    done = 1'b0;
    tmo  = 1'b0;
    eVal = 0;
    eIReady = 0; eIErr = 0; eIRdata = '0;
    eDReady = 0; eDErr = 0; eDRdata = '0;
    if (mBusy) begin
      if (nPReady) begin
        done = 1'b1;
      end else if (cyc - mIssueCyc == TIMEOUT) begin
        done = 1'b1;
        tmo  = 1'b1;
      end
      if (done) begin
        if (mPort == 0) begin
          eIReady = 1'b1;
          eIErr   = tmo;
          eIRdata = tmo ? 32'h0 : nPRdata;
        end else begin
          eDReady = 1'b1;
          eDErr   = tmo;
          eDRdata = tmo ? 32'h0 : nPRdata;
        end
        mLast        = mPort;
        mPend[mPort] = 1'b0;
        mBusy        = 1'b0;
      end
    end else if (oldPend[0] || oldPend[1]) begin
      if (oldPend[0] && oldPend[1]) p = 1 - mLast;
      else                          p = oldPend[1] ? 1 : 0;
      eVal      = 1'b1;
      eInstr    = (p == 0);
      eAddr     = mAddr[p];
      eWdata    = mWdata[p];
      eWstrb    = mWstrb[p];
      mBusy     = 1'b1;
      mPort     = p;
      mIssueCyc = cyc + 1;
    end
    if (nIValid && !oldPend[0]) begin
      mPend[0]  = 1'b1;
      mAddr[0]  = nIAddr;
      mWdata[0] = '0;
      mWstrb[0] = '0;
    end
    if (nDValid && !oldPend[1]) begin
      mPend[1]  = 1'b1;
      mAddr[1]  = nDAddr;
      mWdata[1] = nDWdata;
      mWstrb[1] = nDWstrb;
    end
  endtask

  // Randomized peripheral: on each new request choose silence (timeout), an
  // answer exactly at the watchdog limit, or a short latency; when idle, emit
  // occasional stray per_ready pulses that must be ignored.
  task automatic pickResponse();
    int r;
    nPReady = 1'b0;
    nPRdata = $urandom();
    if (mBusy) begin
      if (cyc == mIssueCyc) begin
        r = int'($urandom_range(7));
        if (r == 0) begin
          respMode = 0;
        end else begin
          respMode = 1;
          if (r == 1) respCyc = mIssueCyc + TIMEOUT;
          else        respCyc = mIssueCyc + int'($urandom_range(4));
        end
      end
      if (respMode == 1 && cyc == respCyc) nPReady = 1'b1;
    end else if ($urandom_range(9) == 0) begin
      nPReady = 1'b1;
    end
  endtask

  task automatic clearInputs();
    nIValid = 1'b0;
    nIAddr  = '0;
    nDValid = 1'b0;
    nDAddr  = '0;
    nDWdata = '0;
    nDWstrb = '0;
    nPReady = 1'b0;
    nPRdata = '0;
    nReset  = 1'b0;
  endtask

  task automatic drivePorts();
    imem_valid = nIValid;
    imem_addr  = nIAddr;
    dmem_valid = nDValid;
    dmem_addr  = nDAddr;
    dmem_wdata = nDWdata;
    dmem_wstrb = nDWstrb;
    per_ready  = nPReady;
    per_rdata  = nPRdata;
  endtask

  // One clock cycle: at the falling edge check this cycle's outputs, then
  // apply this cycle's inputs (optionally with an asynchronous reset pulse
  // inside the low phase) and advance the model.
  task automatic applyStimulus();
    @(negedge clock);
    checkAll();
    if (autoPer) pickResponse();
    if (nReset) begin
      nIValid = 1'b0;
      nDValid = 1'b0;
    end
    drivePorts();
    if (nReset) begin
      reset = 1'b1;
      #2;
      checkZeros();
      modelReset();
      #1;
      reset = 1'b0;
    end
    modelStep();
    cyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      clearInputs();
      applyStimulus();
    end
  endtask

  task automatic respond(input logic [31:0] data);
    clearInputs();
    nPReady = 1'b1;
    nPRdata = data;
    applyStimulus();
  endtask

  task automatic resetPulse();
    clearInputs();
    nReset = 1'b1;
    applyStimulus();
  endtask

  task automatic dmemReq(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    clearInputs();
    nDValid = 1'b1;
    nDAddr  = addr;
    nDWdata = wdata;
    nDWstrb = wstrb;
    applyStimulus();
  endtask

  initial begin
    reset   = 1'b1;
    autoPer = 1'b0;
    cyc     = 0;
    nChecks = 0;
    nBad    = 0;
    respCyc = 0;
    mIssueCyc = 0;
    clearInputs();
    drivePorts();
    modelReset();
    repeat (2) @(negedge clock);
    checkZeros();
    reset = 1'b0;

    // Data read with a one-cycle peripheral: per_valid at +2, ready at +4.
    $display("[TB] data read");
    dmemReq(32'h0000_BFF8, 32'h0, 4'h0);
    runCycles(2);
    checkOutput("rd_per_valid", 32'(per_valid), 32'h1);
    checkOutput("rd_per_addr",  per_addr,        32'h0000_BFF8);
    checkOutput("rd_per_instr", 32'(per_instr), 32'h0);
    checkOutput("rd_per_wstrb", 32'(per_wstrb), 32'h0);
    respond(32'h1234_5678);
    runCycles(1);
    checkOutput("rd_ready", 32'(dmem_ready), 32'h1);
    checkOutput("rd_rdata", dmem_rdata,      32'h1234_5678);
    checkOutput("rd_error", 32'(dmem_error), 32'h0);
    runCycles(2);

    // Tie right after reset: dmem first, imem two cycles after dmem's ack.
    $display("[TB] tie after reset");
    resetPulse();
    clearInputs();
    nIValid = 1'b1;
    nIAddr  = 32'h0000_1000;
    nDValid = 1'b1;
    nDAddr  = 32'h0000_2000;
    applyStimulus();
    runCycles(2);
    checkOutput("tie1_first_instr", 32'(per_instr), 32'h0);
    checkOutput("tie1_first_addr",  per_addr,        32'h0000_2000);
    respond(32'hA5A5_0001);
    runCycles(1);
    checkOutput("tie1_dready", 32'(dmem_ready), 32'h1);
    runCycles(1);
    checkOutput("tie1_second_valid", 32'(per_valid), 32'h1);
    checkOutput("tie1_second_instr", 32'(per_instr), 32'h1);
    checkOutput("tie1_second_addr",  per_addr,        32'h0000_1000);
    checkOutput("tie1_second_wstrb", 32'(per_wstrb), 32'h0);
    respond(32'hA5A5_0002);
    runCycles(1);
    checkOutput("tie1_iready", 32'(imem_ready), 32'h1);
    checkOutput("tie1_irdata", imem_rdata,      32'hA5A5_0002);

    // After a dmem completion the next tie goes to imem.
    $display("[TB] tie after dmem served");
    dmemReq(32'h0000_0040, 32'h0, 4'h0);
    runCycles(2);
    respond(32'h0000_0003);
    runCycles(1);
    clearInputs();
    nIValid = 1'b1;
    nIAddr  = 32'h0000_3000;
    nDValid = 1'b1;
    nDAddr  = 32'h0000_4000;
    applyStimulus();
    runCycles(2);
    checkOutput("tie2_first_instr", 32'(per_instr), 32'h1);
    checkOutput("tie2_first_addr",  per_addr,        32'h0000_3000);
    respond(32'h0000_0004);
    runCycles(2);
    checkOutput("tie2_second_instr", 32'(per_instr), 32'h0);
    respond(32'h0000_0005);
    runCycles(2);

    // Write: fields forwarded, rdata passed through unchanged.
    $display("[TB] data write");
    dmemReq(32'h0000_0000, 32'h0000_0001, 4'hF);
    runCycles(2);
    checkOutput("wr_per_wdata", per_wdata,       32'h0000_0001);
    checkOutput("wr_per_wstrb", 32'(per_wstrb), 32'hF);
    respond(32'h0);
    runCycles(1);
    checkOutput("wr_ready", 32'(dmem_ready), 32'h1);
    checkOutput("wr_rdata", dmem_rdata,      32'h0);
    runCycles(2);

    // Silent peripheral: error completion in cycle 3+TIMEOUT, late ack ignored.
    $display("[TB] timeout");
    dmemReq(32'h0000_0008, 32'h0, 4'h0);
    runCycles(17);
    checkOutput("to_not_yet", 32'(dmem_ready), 32'h0);
    runCycles(1);
    checkOutput("to_ready", 32'(dmem_ready), 32'h1);
    checkOutput("to_error", 32'(dmem_error), 32'h1);
    checkOutput("to_rdata", dmem_rdata,      32'h0);
    runCycles(1);
    respond(32'hDEAD_BEEF);
    runCycles(1);
    checkOutput("to_late_ack", 32'(dmem_ready), 32'h0);
    dmemReq(32'h0000_0010, 32'h0, 4'h0);
    runCycles(2);
    respond(32'h0000_0055);
    runCycles(1);
    checkOutput("to_next_ready", 32'(dmem_ready), 32'h1);
    checkOutput("to_next_error", 32'(dmem_error), 32'h0);
    checkOutput("to_next_rdata", dmem_rdata,      32'h0000_0055);
    runCycles(2);

    // Acknowledge in the same cycle the watchdog reaches TIMEOUT.
    $display("[TB] ack at watchdog limit");
    dmemReq(32'h0000_000C, 32'h0, 4'h0);
    runCycles(16);
    respond(32'h0BAD_F00D);
    runCycles(1);
    checkOutput("bnd_ready", 32'(dmem_ready), 32'h1);
    checkOutput("bnd_error", 32'(dmem_error), 32'h0);
    checkOutput("bnd_rdata", dmem_rdata,      32'h0BAD_F00D);
    runCycles(2);

    // Reset in WAIT abandons the request; a later per_ready is ignored.
    $display("[TB] reset during wait");
    dmemReq(32'h0000_0020, 32'h0, 4'h0);
    runCycles(3);
    resetPulse();
    respond(32'h0000_0077);
    runCycles(1);
    checkOutput("rstw_no_ready", 32'(dmem_ready), 32'h0);
    checkOutput("rstw_no_valid", 32'(per_valid),  32'h0);
    runCycles(3);

    // Second valid while pending is dropped: exactly one forwarded request.
    $display("[TB] drop while pending");
    dmemReq(32'h0000_0030, 32'h0, 4'h0);
    dmemReq(32'h0000_0034, 32'h0, 4'h0);
    runCycles(1);
    checkOutput("drop_valid", 32'(per_valid), 32'h1);
    checkOutput("drop_addr",  per_addr,        32'h0000_0030);
    respond(32'h0000_0099);
    runCycles(1);
    checkOutput("drop_ready", 32'(dmem_ready), 32'h1);
    runCycles(1);
    checkOutput("drop_no_second_a", 32'(per_valid), 32'h0);
    runCycles(1);
    checkOutput("drop_no_second_b", 32'(per_valid), 32'h0);

    // Randomized traffic on both ports against a randomized peripheral.
    $display("[TB] random traffic");
    autoPer = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      clearInputs();
      nIValid = ($urandom_range(2) == 0);
      nIAddr  = $urandom();
      nDValid = ($urandom_range(2) == 0);
      nDAddr  = $urandom();
      nDWdata = $urandom();
      nDWstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
      nReset  = ($urandom_range(499) == 0);
      applyStimulus();
    end
    autoPer = 1'b0;
    runCycles(TIMEOUT + 6);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/periph_arbiter.md
# periph_arbiter

Two-port arbiter that sits directly upstream of the core-local interruptor and other single-slave peripherals. It merges the instruction-fetch port and the data port onto one peripheral request channel using the `valid/instr/addr/wdata/wstrb -> rdata/ready` protocol. It serialises the two requesters with round-robin priority. A watchdog counter completes any request the peripheral never acknowledges, such as an unmapped offset, so neither port can hang.

## Interface
- `TIMEOUT`, default 255: number of waiting cycles without `per_ready` before an error completion. Legal range ≥1. Counter width is `$clog2(TIMEOUT+1)`.
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs clear immediately.
- `imem_valid` in 1: fetch request pulse, one cycle.
- `imem_addr` in 32: fetch address.
- `imem_rdata` out 32: fetch response data.
- `imem_ready` out 1: fetch completion pulse, one cycle.
- `imem_error` out 1: qualifies `imem_ready`; timeout occurred.
- `dmem_valid` in 1: data request pulse, one cycle.
- `dmem_addr` in 32: data address.
- `dmem_wdata` in 32: write data.
- `dmem_wstrb` in 4: byte strobes; 0 means read.
- `dmem_rdata` out 32: data response.
- `dmem_ready` out 1: data completion pulse.
- `dmem_error` out 1: qualifies `dmem_ready`; timeout occurred.
- `per_valid` out 1: peripheral request pulse, one cycle.
- `per_instr` out 1: 1 when the forwarded request is from the fetch port.
- `per_addr` out 32, `per_wdata` out 32, `per_wstrb` out 4: forwarded request fields. Fetches forward `wdata=0`, `wstrb=0`.
- `per_rdata` in 32, `per_ready` in 1: peripheral response.

## Operation
- **Per-port pending register.** Each port has a pending register holding valid, addr, wdata and wstrb.
  - A port `*_valid` with pending clear sets pending and captures the fields.
  - A `*_valid` while that port's pending is set is dropped. Captured fields are unchanged.
  - Pending clears on the edge that produces that port's ready.
- **FSM states:** IDLE and WAIT.
- **IDLE:**
  - If any pending bit is set, pick one port. With both set, pick the port not served last. After reset, "last served" is imem, so dmem wins the first tie.
  - Register the selected fields onto `per_*`, assert `per_valid` for exactly one cycle, clear the watchdog, and go to WAIT.
  - `per_ready` seen in IDLE (a stray or late response) is ignored.
- **WAIT:**
  - `per_addr`, `per_wdata`, `per_wstrb` and `per_instr` are held stable; `per_valid` is 0 after the first WAIT cycle.
  - The watchdog holds k in the k-th WAIT cycle, where the first WAIT cycle is 0.
  - `per_ready=1`: register `per_rdata` to the selected port's rdata with ready=1, error=0. Update last-served. Go to IDLE.
  - Otherwise, if the watchdog equals `TIMEOUT`: selected port gets ready=1, error=1, rdata=0. Update last-served. Go to IDLE.
  - `per_ready` in the same cycle the watchdog equals `TIMEOUT`: ready wins, error=0.
  - Otherwise the watchdog increments.
- **Writes:** rdata is forwarded unchanged; the peripheral returns 0.
- **Back-to-back requests:** a port may issue its next valid in the same cycle its ready is high. That valid is captured, because pending clears on that edge.

## Timing
- **Reset values:** every output is 0, the FSM is in IDLE, both pending bits are clear, and the watchdog is 0. Reset asserted mid-WAIT abandons the request: no ready is ever produced for it, and a subsequent `per_ready` is ignored.
- **Latency with a one-cycle peripheral:** valid in cycle 0 → pending set in cycle 1 (IDLE) → `per_valid` in cycle 2 → `per_ready` in cycle 3 → port ready in cycle 4.
- **Timeout latency:** `per_valid` in cycle 2 → error ready in cycle `3+TIMEOUT`.
- **Pulse widths:** `*_ready` and `*_error` are single-cycle pulses, and `*_rdata` is valid only while ready is high (0 otherwise). At most one port ready is high per cycle.
- **Issue gap:** the minimum gap between consecutive `per_valid` pulses is 2 cycles (WAIT→IDLE→WAIT).

## Test plan
- **Data read:** `dmem` read `addr=0x0000BFF8`, `wstrb=0` in cycle 0 → `per_valid` in cycle 2 with `per_addr=0x0000BFF8`, `per_instr=0`, `per_wstrb=0`. Peripheral returns `per_rdata=0x12345678` in cycle 3 → `dmem_ready=1`, `dmem_rdata=0x12345678`, `dmem_error=0` in cycle 4.
- **Tie after reset:** `imem_valid` and `dmem_valid` in the same cycle after reset → dmem is forwarded first. imem is forwarded (`per_instr=1`, `per_wstrb=0`) 2 cycles after dmem's `per_ready`. A second tie then serves imem first.
- **Data write:** `dmem` write `addr=0`, `wdata=1`, `wstrb=0xF` → `per_wdata=1`, `per_wstrb=0xF`. Peripheral ready with rdata 0 → `dmem_ready=1`, `dmem_rdata=0`.
- **Timeout:** `TIMEOUT=15`, dmem read of unmapped `addr=0x8`, peripheral silent → `dmem_ready=1`, `dmem_error=1`, `dmem_rdata=0` in cycle 18. A late `per_ready` in cycle 20 produces no response. A following request completes normally.
- **Ready at timeout boundary:** `TIMEOUT=15`, `per_ready` in the cycle the watchdog equals 15 → `error=0` and rdata is forwarded.
- **Reset and drop rules:**
  - Reset pulsed during WAIT → all outputs 0 within the reset cycle. No ready is issued for the abandoned request.
  - A second `dmem_valid` while dmem is pending is dropped: exactly one `per_valid`, carrying the first address.
